video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates the raster timing that drives the RGB pattern stage: hsync, vsync, blank and a linear active-pixel index, all synchronous to the pixel clock.
- Sits between the pixel-clock domain and the pattern/colour stage.
- Default timing is 800x600@60 (40 MHz pixel clock); every field is parameterised.
- All outputs are registered, so the downstream stage can re-register them with a fixed one-cycle skew.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
H_SYNC_POL, 1, hsync active level
V_SYNC_POL, 1, vsync active level
POS_W, 20, width of o_pixel_pos

Ports:
i_clk  input  1  pixel clock; all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_en  input  1  clock enable; counters and outputs advance only when 1
o_hsync  output  1  horizontal sync, polarity H_SYNC_POL
o_vsync  output  1  vertical sync, polarity V_SYNC_POL
o_blank  output  1  1 outside the active area
o_pixel_pos  output  POS_W  linear active index, y*H_ACTIVE+x
o_pos_x  output  12  current column, 0..H_TOTAL-1
o_pos_y  output  12  current line, 0..V_TOTAL-1
o_frame_start  output  1  one-cycle pulse at (0,0)

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Reset, asynchronous while i_rst=1:
  - o_hsync = ~H_SYNC_POL, o_vsync = ~V_SYNC_POL.
  - o_blank = 1, o_pixel_pos = 0, o_pos_x = 0, o_pos_y = 0, o_frame_start = 0.
  - Internal "next position" counters = (0,0).
- Each rising edge with i_en=1:
  - Outputs load the decode of the next position (h,v).
  - The counter then advances: h increments; at h=H_TOTAL-1 it wraps to 0 and v increments; at v=V_TOTAL-1 with h wrap, v wraps to 0.
  - The first enabled edge after reset release presents (0,0).
- Edges with i_en=0: all outputs and counters hold; o_frame_start is forced to 0 and does not repeat while stalled.
- Decode for position (h,v):
  - o_pos_x = h, o_pos_y = v.
  - o_blank = (h >= H_ACTIVE) | (v >= V_ACTIVE).
  - o_hsync = H_SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else inverted.
  - o_vsync = V_SYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else inverted. Transitions are whole-line, aligned to h=0.
  - o_frame_start = 1 only for (0,0).
- o_pixel_pos:
  - Loads 0 at (0,0).
  - Increments by 1 on every later active (non-blank) position.
  - Holds its last value during blanking.
  - Implemented as an incrementer (no multiplier). At (H_ACTIVE-1, V_ACTIVE-1) it equals H_ACTIVE*V_ACTIVE-1 (479999 default); it returns to 0 at the next frame.
- Width rule: POS_W must hold H_ACTIVE*V_ACTIVE-1, and 12 bits must hold H_TOTAL-1 and V_TOTAL-1. Violations are an elaboration error (generate-time check).
- Mid-frame reset: outputs return to reset values immediately (asynchronous). The timing restarts at (0,0) on the first enabled edge after release; no partial-frame state is retained.
- i_en asserted in the same cycle as reset release: the first edge with i_rst=0 and i_en=1 presents (0,0).

Test Plan:
1. Assert i_rst with i_en=1 and check outputs mid-cycle -> hsync=0, vsync=0, blank=1, pos=0, frame_start=0. Release reset -> first edge gives x=0, y=0, blank=0, frame_start=1.
2. Defaults, i_en=1 for 3 lines -> hsync rising edges exactly 1056 cycles apart. Each is high 128 cycles, starting 840 cycles after the line start. Blank is high for cycles 800..1055 of each line.
3. Defaults, two full frames -> frame_start pulses 663168 cycles apart. vsync high for 4224 cycles starting at line 601, h=0. Blank is high for all of lines 600..627.
4. Track o_pixel_pos -> 799 at (799,0); 800 at (0,1); holds 799 during the line-0 blanking; 479999 at (799,599); 0 at the next frame_start.
5. Toggle i_en in a 1-on/2-off pattern across a line wrap and the frame wrap -> every output holds while i_en=0. The sequence matches case 2 when compressed to enabled cycles. frame_start is high for exactly one enabled edge.
6. Small parameters (H 4/1/2/1, V 3/1/1/1, POS_W 4); pulse i_rst at (2,1) mid-frame -> immediate reset values; frame restarts at (0,0) after release. Line period is 8 cycles, frame period 48, final pixel_pos 11.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered hsync/vsync/blank, raster position and a
// linear active-pixel index, all advancing only on enabled pixel-clock edges.
module video_timing_gen #(
   parameter int   H_ACTIVE   = 800,
   parameter int   H_FP       = 40,
   parameter int   H_SYNC     = 128,
   parameter int   H_BP       = 88,
   parameter int   V_ACTIVE   = 600,
   parameter int   V_FP       = 1,
   parameter int   V_SYNC     = 4,
   parameter int   V_BP       = 23,
   parameter logic H_SYNC_POL = 1'b1,
   parameter logic V_SYNC_POL = 1'b1,
   parameter int   POS_W      = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_blank,
   output logic [POS_W-1:0] o_pixel_pos,
   output logic [11:0]      o_pos_x,
   output logic [11:0]      o_pos_y,
   output logic             o_frame_start
);

   localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam longint PIX_MAX = longint'(H_ACTIVE) * longint'(V_ACTIVE) - 64'sd1;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   // Thresholds carry a 13th bit so a sync ending exactly at 4096 cannot alias to 0
   localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
   localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
   localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

   if ((PIX_MAX >> POS_W) != 64'sd0) begin : g_pos_w_check
      $error("POS_W too narrow for H_ACTIVE*V_ACTIVE-1");
   end
   if ((H_TOTAL > 32'sd4096) || (V_TOTAL > 32'sd4096)) begin : g_pos_xy_check
      $error("H_TOTAL-1 or V_TOTAL-1 does not fit in 12 bits");
   end

   logic [11:0]      h_r, v_r, h_nxt_s, v_nxt_s;
   logic             blank_s, hsync_s, vsync_s, first_s;
   logic [POS_W-1:0] pos_nxt_s;

   logic             hsync_r, vsync_r, blank_r, frame_start_r;
   logic [POS_W-1:0] pixel_pos_r;
   logic [11:0]      pos_x_r, pos_y_r;

   // Decode of the pending position and the counter advance that follows it
   always_comb begin
      h_nxt_s   = h_r;
      v_nxt_s   = v_r;
      pos_nxt_s = pixel_pos_r;
      if (h_r == H_LAST) begin
         h_nxt_s = 12'd0;
         if (v_r == V_LAST) begin
            v_nxt_s = 12'd0;
         end else begin
            v_nxt_s = v_r + 12'd1;
         end
      end else begin
         h_nxt_s = h_r + 12'd1;
      end

      blank_s = ({1'b0, h_r} >= H_ACT) || ({1'b0, v_r} >= V_ACT);
      hsync_s = (({1'b0, h_r} >= HS_START) && ({1'b0, h_r} < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_s = (({1'b0, v_r} >= VS_START) && ({1'b0, v_r} < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      first_s = (h_r == 12'd0) && (v_r == 12'd0);

      if (first_s) begin
         pos_nxt_s = '0;
      end else if (!blank_s) begin
         pos_nxt_s = pixel_pos_r + {{(POS_W-1){1'b0}}, 1'b1};
      end else begin
         pos_nxt_s = pixel_pos_r;
      end
   end

   // Counters and registered outputs; a stalled edge holds everything but drops frame_start
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         h_r           <= 12'd0;
         v_r           <= 12'd0;
         hsync_r       <= ~H_SYNC_POL;
         vsync_r       <= ~V_SYNC_POL;
         blank_r       <= 1'b1;
         pixel_pos_r   <= '0;
         pos_x_r       <= 12'd0;
         pos_y_r       <= 12'd0;
         frame_start_r <= 1'b0;
      end else if (i_en) begin
         h_r           <= h_nxt_s;
         v_r           <= v_nxt_s;
         hsync_r       <= hsync_s;
         vsync_r       <= vsync_s;
         blank_r       <= blank_s;
         pixel_pos_r   <= pos_nxt_s;
         pos_x_r       <= h_r;
         pos_y_r       <= v_r;
         frame_start_r <= first_s;
      end else begin
         frame_start_r <= 1'b0;
      end
   end

   assign o_hsync       = hsync_r;
   assign o_vsync       = vsync_r;
   assign o_blank       = blank_r;
   assign o_pixel_pos   = pixel_pos_r;
   assign o_pos_x       = pos_x_r;
   assign o_pos_y       = pos_y_r;
   assign o_frame_start = frame_start_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 800x600 instance for line timing, small instance for frame,
// stall and mid-frame reset behaviour.
module tb_video_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        d_rst, d_en, d_hsync, d_vsync, d_blank, d_fs;
   logic [19:0] d_pos;
   logic [11:0] d_x, d_y;

   logic        s_rst, s_en, s_hsync, s_vsync, s_blank, s_fs;
   logic [3:0]  s_pos;
   logic [11:0] s_x, s_y;
   logic [31:0] s_obs;

   assign s_obs = {s_x, s_y, s_blank, s_hsync, s_vsync, s_fs, s_pos};

   video_timing_gen dut_d (
      .i_clk(clk), .i_rst(d_rst), .i_en(d_en),
      .o_hsync(d_hsync), .o_vsync(d_vsync), .o_blank(d_blank),
      .o_pixel_pos(d_pos), .o_pos_x(d_x), .o_pos_y(d_y), .o_frame_start(d_fs)
   );

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .POS_W(4)
   ) dut_s (
      .i_clk(clk), .i_rst(s_rst), .i_en(s_en),
      .o_hsync(s_hsync), .o_vsync(s_vsync), .o_blank(s_blank),
      .o_pixel_pos(s_pos), .o_pos_x(s_x), .o_pos_y(s_y), .o_frame_start(s_fs)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected small-instance outputs n enabled edges after reset release (8x6 raster)
   function automatic logic [31:0] small_exp(input int n);
      int   ex, ey, ep;
      logic eb, ehs, evs, efs;
      ex  = n % 8;
      ey  = (n / 8) % 6;
      eb  = (ex >= 4) || (ey >= 3);
      ehs = (ex >= 5) && (ex < 7);
      evs = (ey == 4);
      efs = (ex == 0) && (ey == 0);
      if (ey >= 3)      ep = 11;
      else if (ex >= 4) ep = ey * 4 + 3;
      else              ep = ey * 4 + ex;
      return {12'(ex), 12'(ey), eb, ehs, evs, efs, 4'(ep)};
   endfunction

   task automatic test_reset();
      d_rst = 1'b1; d_en = 1'b1; s_rst = 1'b1; s_en = 1'b0;
      repeat (3) step();
      #3;
      n_checks++; if (d_hsync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b expected 0", d_hsync); end
      n_checks++; if (d_vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b expected 0", d_vsync); end
      n_checks++; if (d_blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b expected 1", d_blank); end
      n_checks++; if (d_pos !== 20'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", d_pos); end
      n_checks++; if ({d_x, d_y} !== 24'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", d_x, d_y); end
      n_checks++; if (d_fs !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", d_fs); end
      @(negedge clk);
      d_rst = 1'b0;
      step();
      n_checks++; if ({d_x, d_y} !== 24'd0) begin n_fail++; $display("FAIL first_xy: got %0d,%0d expected 0,0", d_x, d_y); end
      n_checks++; if (d_blank !== 1'b0) begin n_fail++; $display("FAIL first_blank: got %b expected 0", d_blank); end
      n_checks++; if (d_fs !== 1'b1) begin n_fail++; $display("FAIL first_fs: got %b expected 1", d_fs); end
      n_checks++; if (d_pos !== 20'd0) begin n_fail++; $display("FAIL first_pos: got %0d expected 0", d_pos); end
   endtask

   // Three 1056-cycle lines on the default instance; cycle k shows column k%1056
   task automatic test_line_timing();
      int   rise[$];
      int   fall[$];
      int   hs_high = 0;
      int   blank_bad = 0;
      int   vs_bad = 0;
      logic prev_hs;
      prev_hs = d_hsync;
      for (int k = 1; k < 3 * 1056; k++) begin
         step();
         if (d_hsync && !prev_hs) rise.push_back(k);
         if (!d_hsync && prev_hs) fall.push_back(k);
         prev_hs = d_hsync;
         if (d_hsync) hs_high++;
         if (d_blank !== ((k % 1056) >= 800)) blank_bad++;
         if (d_vsync !== 1'b0) vs_bad++;
         if (k == 799) begin
            n_checks++; if ({d_x, d_pos} !== {12'd799, 20'd799}) begin n_fail++; $display("FAIL pos_799_0: got x=%0d pos=%0d expected x=799 pos=799", d_x, d_pos); end
         end
         if (k == 1000) begin
            n_checks++; if (d_pos !== 20'd799) begin n_fail++; $display("FAIL pos_hold_blank: got %0d expected 799", d_pos); end
         end
         if (k == 1056) begin
            n_checks++; if ({d_x, d_y, d_pos} !== {12'd0, 12'd1, 20'd800}) begin n_fail++; $display("FAIL pos_0_1: got x=%0d y=%0d pos=%0d expected 0,1,800", d_x, d_y, d_pos); end
         end
      end
      n_checks++;
      if (rise.size() != 3 || fall.size() != 3) begin
         n_fail++; $display("FAIL hsync_edges: got %0d rises %0d falls expected 3 3", rise.size(), fall.size());
      end else begin
         n_checks++; if (rise[0] != 840) begin n_fail++; $display("FAIL hsync_start: got %0d expected 840", rise[0]); end
         n_checks++; if (rise[1] - rise[0] != 1056 || rise[2] - rise[1] != 1056) begin n_fail++; $display("FAIL hsync_period: got %0d %0d expected 1056", rise[1] - rise[0], rise[2] - rise[1]); end
         n_checks++; if (fall[0] - rise[0] != 128) begin n_fail++; $display("FAIL hsync_width: got %0d expected 128", fall[0] - rise[0]); end
      end
      n_checks++; if (hs_high != 384) begin n_fail++; $display("FAIL hsync_high_total: got %0d expected 384", hs_high); end
      n_checks++; if (blank_bad != 0) begin n_fail++; $display("FAIL line_blank: got %0d bad cycles expected 0", blank_bad); end
      n_checks++; if (vs_bad != 0) begin n_fail++; $display("FAIL line_vsync: got %0d bad cycles expected 0", vs_bad); end
   endtask

   task automatic test_stall_default();
      d_en = 1'b0;
      repeat (3) begin
         step();
         n_checks++; if ({d_x, d_y, d_blank, d_fs} !== {12'd1055, 12'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL stall_hold: got x=%0d y=%0d b=%b fs=%b expected 1055,2,1,0", d_x, d_y, d_blank, d_fs); end
      end
      d_en = 1'b1;
      step();
      n_checks++; if ({d_x, d_y, d_blank, d_pos} !== {12'd0, 12'd3, 1'b0, 20'd2400}) begin n_fail++; $display("FAIL stall_resume: got x=%0d y=%0d b=%b pos=%0d expected 0,3,0,2400", d_x, d_y, d_blank, d_pos); end
   endtask

   // Two full small frames (96 edges) compared cycle by cycle, plus frame_start spacing
   task automatic test_small_frame();
      int fs_at[$];
      s_en = 1'b1;
      @(negedge clk);
      s_rst = 1'b0;
      for (int n = 0; n <= 96; n++) begin
         step();
         if (s_fs) fs_at.push_back(n);
         n_checks++; if (s_obs !== small_exp(n)) begin n_fail++; $display("FAIL small_frame n=%0d: got %h expected %h", n, s_obs, small_exp(n)); end
      end
      n_checks++;
      if (fs_at.size() != 3) begin
         n_fail++; $display("FAIL small_fs_count: got %0d expected 3", fs_at.size());
      end else begin
         n_checks++; if (fs_at[1] - fs_at[0] != 48 || fs_at[2] - fs_at[1] != 48) begin n_fail++; $display("FAIL small_frame_period: got %0d %0d expected 48", fs_at[1] - fs_at[0], fs_at[2] - fs_at[1]); end
      end
   endtask

   // 1-on/2-off enable across line wraps and the frame wrap at enabled edge 144
   task automatic test_small_stall();
      int          fs_edges = 0;
      logic [31:0] held;
      for (int e = 97; e < 160; e++) begin
         s_en = 1'b1;
         step();
         if (s_fs) fs_edges++;
         n_checks++; if (s_obs !== small_exp(e)) begin n_fail++; $display("FAIL stall_enabled e=%0d: got %h expected %h", e, s_obs, small_exp(e)); end
         held = small_exp(e) & ~32'h0000_0010;
         s_en = 1'b0;
         repeat (2) begin
            step();
            n_checks++; if (s_obs !== held) begin n_fail++; $display("FAIL stall_disabled e=%0d: got %h expected %h", e, s_obs, held); end
         end
      end
      n_checks++; if (fs_edges != 1) begin n_fail++; $display("FAIL stall_fs_count: got %0d expected 1", fs_edges); end
      s_en = 1'b1;
   endtask

   task automatic test_small_midreset();
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (s_x == 12'd2 && s_y == 12'd1) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL midreset_reach: got no (2,1) within 60 edges expected (2,1)"); end
      s_rst = 1'b1;
      #2;
      n_checks++; if (s_obs !== 32'h0000_0080) begin n_fail++; $display("FAIL midreset_async: got %h expected %h", s_obs, 32'h0000_0080); end
      @(negedge clk);
      s_rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         step();
         n_checks++; if (s_obs !== small_exp(n)) begin n_fail++; $display("FAIL midreset_restart n=%0d: got %h expected %h", n, s_obs, small_exp(n)); end
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_stall_default();
      test_small_frame();
      test_small_stall();
      test_small_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
